dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the word-wide, 1-cycle-read-latency data memory. Port 0 is the CPU load/store unit and port 1 is the debug/DMA port. The block shares the memory between them round-robin. It handles RISC-V byte/half/word loads with sign/zero extension, and it performs sub-word stores as read-modify-write, because the memory only writes whole words.

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port data memory sequencer with sub-word loads and RMW stores (option: DMEM_ARB_FIXED_PRIO_EN)
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_unsigned,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_unsigned,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [31:0]           p1_rdata,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE, RESP} state_t;
  state_t state, state_nx;
  logic win, any_req, accept, bad, resp;
  logic s_we, s_uns, l_we, l_uns, l_port, l_err;
  logic [1:0] s_size, l_size;
  logic [ADDR_WIDTH-1:0] s_addr, l_addr;
  logic [31:0] s_wdata, l_wdata, rdata_q, mask, merged, shifted, ext;
  logic [4:0] shift;
  assign any_req = p0_req | p1_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign win = !p0_req;
`else
  logic rr;
  assign win = (p0_req & p1_req) ? rr : p1_req;
`endif
  assign s_we    = win ? p1_we       : p0_we;
  assign s_uns   = win ? p1_unsigned : p0_unsigned;
  assign s_size  = win ? p1_size     : p0_size;
  assign s_addr  = win ? p1_addr     : p0_addr;
  assign s_wdata = win ? p1_wdata    : p0_wdata;
  assign bad = (s_size == 2'b11) | (s_size == 2'b01 & s_addr[0]) | (s_size == 2'b10 & |s_addr[1:0]);
  assign accept = state == IDLE & any_req;
  assign shift = l_size == 2'b00 ? {l_addr[1:0], 3'b000} : {l_addr[1], 4'b0000};
  assign mask = l_size == 2'b00 ? 32'h0000_00ff << shift : 32'h0000_ffff << shift;
  assign merged = (mem_read_data & ~mask) | ((l_wdata << shift) & mask);
  assign shifted = mem_read_data >> shift;
  assign ext = l_size == 2'b00 ? {{24{~l_uns & shifted[7]}}, shifted[7:0]} :
               l_size == 2'b01 ? {{16{~l_uns & shifted[15]}}, shifted[15:0]} : mem_read_data;
  // Next state and memory drive; everything toward memory is forced quiet while reset is high
  always_comb begin
    state_nx = state;
    mem_write_enable = 1'b0;
    mem_read_enable = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    case (state)
      IDLE: if (any_req) begin
        mem_addr = {s_addr[ADDR_WIDTH-1:2], 2'b00};
        if (bad) state_nx = RESP;
        else if (s_we & s_size == 2'b10) begin
          mem_write_enable = 1'b1;
          mem_write_data = s_wdata;
          state_nx = RESP;
        end else begin
          mem_read_enable = 1'b1;
          state_nx = s_we ? RMW_WRITE : LOAD_WAIT;
        end
      end
      LOAD_WAIT: state_nx = RESP;
      RMW_WRITE: begin
        mem_write_enable = 1'b1;
        mem_addr = {l_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_write_data = merged;
        state_nx = RESP;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      mem_write_enable = 1'b0;
      mem_read_enable = 1'b0;
      mem_addr = '0;
      mem_write_data = '0;
    end
  end
  // State register, request latch and load result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      {l_we, l_uns, l_port, l_err, l_size} <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        {l_we, l_uns, l_port, l_err, l_size} <= {s_we, s_uns, win, bad, s_size};
        l_addr <= s_addr;
        l_wdata <= s_wdata;
      end
      if (state == LOAD_WAIT) rdata_q <= ext;
    end
  end
`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: the port not granted most recently is favoured
  always_ff @(posedge clock) begin
    if (reset) rr <= 1'b0;
    else if (accept) rr <= ~win;
  end
`endif
  assign resp = state == RESP & !reset;
  assign p0_ack = resp & !l_port & !l_err;
  assign p0_err = resp & !l_port & l_err;
  assign p1_ack = resp & l_port & !l_err;
  assign p1_err = resp & l_port & l_err;
  assign p0_rdata = (p0_ack & !l_we) ? rdata_q : 32'h0;
  assign p1_rdata = (p1_ack & !l_we) ? rdata_q : 32'h0;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a registered-read memory model
module tb_dmem_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic p0_req = 0, p0_we = 0, p0_unsigned = 0, p1_req = 0, p1_we = 0, p1_unsigned = 0;
  logic [1:0] p0_size = 0, p1_size = 0;
  logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
  logic p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic mem_write_enable, mem_read_enable, busy;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [31:0] mem [16];
  int checks = 0, failures = 0;

  dmem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write_enable) mem[mem_addr[5:2]] <= mem_write_data;
    if (mem_read_enable) mem_read_data <= mem[mem_addr[5:2]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input bit p, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic rq);
    if (p) begin
      p1_we = we; p1_size = sz; p1_unsigned = uns; p1_addr = a; p1_wdata = wd; p1_req = rq;
    end else begin
      p0_we = we; p0_size = sz; p0_unsigned = uns; p0_addr = a; p0_wdata = wd; p0_req = rq;
    end
  endtask

  task automatic xact(input string tag, input bit p, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input bit exp_err, input int exp_lat,
                      input logic [31:0] exp_rd, input logic [31:0] exp_wd);
    int n = 0;
    bit done = 0;
    bit word_st = we && sz == 2'b10;
    set_port(p, we, sz, uns, a, wd, 1'b1);
    #1;
    chk({tag, " accept_re"}, mem_read_enable, !exp_err && !word_st);
    chk({tag, " accept_we"}, mem_write_enable, !exp_err && word_st);
    if (!exp_err) chk({tag, " accept_addr"}, mem_addr, {a[31:2], 2'b00});
    if (!exp_err && word_st) chk({tag, " word_data"}, mem_write_data, exp_wd);
    while (!done && n < 8) begin
      tick;
      n++;
      if (n == 1 && we && !word_st && !exp_err) begin
        chk({tag, " rmw_we"}, mem_write_enable, 1);
        chk({tag, " rmw_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, " rmw_data"}, mem_write_data, exp_wd);
      end
      if (p0_ack | p0_err | p1_ack | p1_err) done = 1;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " ack"}, p ? p1_ack : p0_ack, !exp_err);
    chk({tag, " err"}, p ? p1_err : p0_err, exp_err);
    chk({tag, " rdata"}, p ? p1_rdata : p0_rdata, exp_rd);
    chk({tag, " other_quiet"}, p ? {p0_ack, p0_err, p0_rdata} : {p1_ack, p1_err, p1_rdata}, 0);
    chk({tag, " busy"}, busy, 1);
    set_port(p, 0, 0, 0, 0, 0, 1'b0);
    tick;
  endtask

  initial begin
    int ports[4], cyc[4];
    int k, n, exp_port;
    p0_req = 1;
    tick;
    tick;
    chk("rst re", mem_read_enable, 0);
    chk("rst we", mem_write_enable, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_write_data, 0);
    chk("rst busy", busy, 0);
    chk("rst acks", {p0_ack, p0_err, p1_ack, p1_err, p0_rdata, p1_rdata}, 0);
    p0_req = 0;
    reset = 0;
    tick;
    xact("sw10", 0, 1, 2'b10, 0, 32'h10, 32'h8899AABB, 0, 1, 0, 32'h8899AABB);
    xact("lw10", 0, 0, 2'b10, 0, 32'h10, 0, 0, 2, 32'h8899AABB, 0);
    xact("lb13", 0, 0, 2'b00, 0, 32'h13, 0, 0, 2, 32'hFFFFFF88, 0);
    xact("lbu13", 0, 0, 2'b00, 1, 32'h13, 0, 0, 2, 32'h00000088, 0);
    xact("lh12", 0, 0, 2'b01, 0, 32'h12, 0, 0, 2, 32'hFFFF8899, 0);
    xact("lhu10", 0, 0, 2'b01, 1, 32'h10, 0, 0, 2, 32'h0000AABB, 0);
    xact("sb11", 1, 1, 2'b00, 0, 32'h11, 32'h123456CC, 0, 2, 0, 32'h8899CCBB);
    xact("sh12", 1, 1, 2'b01, 0, 32'h12, 32'h00007777, 0, 2, 0, 32'h7777CCBB);
    xact("lw10b", 0, 0, 2'b10, 0, 32'h10, 0, 0, 2, 32'h7777CCBB, 0);
    xact("sw14", 1, 1, 2'b10, 0, 32'h14, 32'h11112222, 0, 1, 0, 32'h11112222);
    xact("lb14", 1, 0, 2'b00, 0, 32'h14, 0, 0, 2, 32'h00000022, 0);
    xact("lh16", 1, 0, 2'b01, 0, 32'h16, 0, 0, 2, 32'h00001111, 0);
    xact("lw_mis", 0, 0, 2'b10, 0, 32'h12, 0, 1, 1, 0, 0);
    xact("sz11", 0, 0, 2'b11, 0, 32'h10, 0, 1, 1, 0, 0);
    xact("sh_mis", 1, 1, 2'b01, 0, 32'h11, 32'hFFFF, 1, 1, 0, 0);
    reset = 1;
    tick;
    reset = 0;
    set_port(0, 0, 2'b10, 0, 32'h10, 0, 1'b1);
    set_port(1, 0, 2'b10, 0, 32'h14, 0, 1'b1);
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      tick;
      if (k < 4 && p0_ack) begin
        chk("arb p0 rdata", p0_rdata, 32'h7777CCBB);
        ports[k] = 0; cyc[k] = i; k++;
      end else if (k < 4 && p1_ack) begin
        chk("arb p1 rdata", p1_rdata, 32'h11112222);
        ports[k] = 1; cyc[k] = i; k++;
      end
    end
    p0_req = 0;
    p1_req = 0;
    chk("arb count", k, 4);
    for (int j = 0; j < k; j++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = j % 2;
`endif
      chk($sformatf("arb port%0d", j), ports[j], exp_port);
      chk($sformatf("arb cycle%0d", j), cyc[j], 2 + 3 * j);
    end
    tick;
    set_port(0, 0, 2'b10, 0, 32'h10, 0, 1'b1);
    tick;
    chk("rstlw busy", busy, 1);
    reset = 1;
    p0_req = 0;
    #1;
    chk("rstlw mem", {mem_read_enable, mem_write_enable}, 0);
    tick;
    reset = 0;
    #1;
    chk("rstlw idle", busy, 0);
    chk("rstlw noack", {p0_ack, p0_err, p1_ack, p1_err}, 0);
    tick;
    chk("rstlw noack2", {p0_ack, p0_err, p1_ack, p1_err}, 0);
    set_port(0, 0, 2'b10, 0, 32'h10, 0, 1'b1);
    set_port(1, 0, 2'b10, 0, 32'h14, 0, 1'b1);
    n = 0;
    while (!(p0_ack | p1_ack) && n < 6) begin
      tick;
      n++;
    end
    chk("post_rst winner", {p0_ack, p1_ack}, 2'b10);
    chk("post_rst latency", n, 2);
    p0_req = 0;
    p1_req = 0;
    tick;
    set_port(1, 1, 2'b00, 0, 32'h11, 32'hEE, 1'b1);
    tick;
    chk("rstrmw busy", busy, 1);
    reset = 1;
    p1_req = 0;
    #1;
    chk("rstrmw we", mem_write_enable, 0);
    tick;
    reset = 0;
    #1;
    chk("rstrmw idle", busy, 0);
    chk("rstrmw noack", {p0_ack, p0_err, p1_ack, p1_err}, 0);
    tick;
    chk("rstrmw noack2", {p0_ack, p0_err, p1_ack, p1_err}, 0);
    xact("lw_after", 0, 0, 2'b10, 0, 32'h10, 0, 0, 2, 32'h7777CCBB, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
